// File: rtl/fir_multich.sv
// fir_multich: time-shared multichannel FIR over one coefficient set with rounded, saturated output
module fir_multich #(
  parameter int DW = 18,
  parameter int CW = 18,
  parameter int NTAPS = 64,
  parameter int NCH = 2,
  localparam int CAW = $clog2(NTAPS),
  localparam int ACCW = DW + CW + $clog2(NTAPS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH*DW-1:0] datain,
  input  logic              endata,
  input  logic              bypass,
  output logic [NCH*DW-1:0] dataout,
  output logic              dataout_valid,
  output logic              busy,
  output logic              overrun,
  output logic [CAW-1:0]    coefaddress,
  input  logic [CW-1:0]     coefdata
);
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1;
  localparam logic signed [ACCW:0] RND = (ACCW + 1)'(1) << (CW - 2);
  localparam logic signed [ACCW:0] MAXV = {{(ACCW - DW + 2){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [ACCW:0] MINV = ~MAXV;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [CAW-1:0] tap_q, tap_d, wptr_q, wptr_d, ridx;
  logic [CHW-1:0] ch_q, ch_d, pch_q, pch_d;
  logic [CAW:0] fill_q, fill_d;
  logic byp_q, byp_d, ovr_q, ovr_d, vld_q, vld_d, last_q, last_d, oval_q, oval_d;
  logic signed [DW-1:0] smp_q, smp_d;
  logic signed [DW+CW-1:0] prod;
  logic signed [ACCW-1:0] acc_q, acc_d, sum;
  logic [NCH*DW-1:0] dout_q, dout_d;
  logic [DW-1:0] buf_q [NCH][NTAPS];
  logic [DW-1:0] res_q [NCH];
  logic accept, tap_end, ch_end;
  function automatic logic [DW-1:0] sat(input logic signed [ACCW-1:0] a);
    logic signed [ACCW:0] s;
    s = ($signed({a[ACCW-1], a}) + RND) >>> (CW - 1);
    return s > MAXV ? MAXV[DW-1:0] : s < MINV ? MINV[DW-1:0] : s[DW-1:0];
  endfunction
  always_comb begin
    accept = state_q == IDLE && endata;
    tap_end = tap_q == CAW'(NTAPS - 1);
    ch_end = ch_q == CHW'(NCH - 1);
    ridx = wptr_q - tap_q + (wptr_q < tap_q ? CAW'(NTAPS) : '0);
    smp_d = {1'b0, tap_q} < fill_q ? buf_q[ch_q][ridx] : '0;
    prod = $signed(coefdata) * smp_q;
    sum = acc_q + {{CAW{prod[DW+CW-1]}}, prod};
    acc_d = vld_q ? (last_q ? '0 : sum) : acc_q;
    vld_d = state_q == RUN;
    last_d = tap_end;
    pch_d = ch_q;
    ovr_d = ovr_q | (endata & state_q != IDLE);
    state_d = state_q;
    tap_d = tap_q;
    ch_d = ch_q;
    wptr_d = wptr_q;
    fill_d = fill_q;
    byp_d = byp_q;
    oval_d = 1'b0;
    dout_d = dout_q;
    case (state_q)
      IDLE: if (endata) begin
        state_d = RUN;
        byp_d = bypass;
        fill_d = fill_q == (CAW + 1)'(NTAPS) ? fill_q : fill_q + 1'b1;
      end
      RUN: begin
        tap_d = tap_end ? '0 : tap_q + 1'b1;
        ch_d = tap_end ? (ch_end ? '0 : ch_q + 1'b1) : ch_q;
        state_d = tap_end && ch_end ? DRAIN : RUN;
      end
      DRAIN: begin
        tap_d = tap_q == CAW'(1) ? '0 : tap_q + 1'b1;
        state_d = tap_q == CAW'(1) ? DONE : DRAIN;
        if (tap_q == CAW'(1)) begin
          oval_d = 1'b1;
          for (int c = 0; c < NCH; c++) dout_d[c*DW +: DW] = byp_q ? buf_q[c][wptr_q] : res_q[c];
        end
      end
      default: begin
        state_d = IDLE;
        wptr_d = wptr_q == CAW'(NTAPS - 1) ? '0 : wptr_q + 1'b1;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      tap_q <= '0;
      ch_q <= '0;
      pch_q <= '0;
      wptr_q <= '0;
      fill_q <= '0;
      byp_q <= 1'b0;
      ovr_q <= 1'b0;
      vld_q <= 1'b0;
      last_q <= 1'b0;
      oval_q <= 1'b0;
      smp_q <= '0;
      acc_q <= '0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      tap_q <= tap_d;
      ch_q <= ch_d;
      pch_q <= pch_d;
      wptr_q <= wptr_d;
      fill_q <= fill_d;
      byp_q <= byp_d;
      ovr_q <= ovr_d;
      vld_q <= vld_d;
      last_q <= last_d;
      oval_q <= oval_d;
      smp_q <= smp_d;
      acc_q <= acc_d;
      dout_q <= dout_d;
    end
  end
  always_ff @(posedge clock) begin
    if (accept) for (int c = 0; c < NCH; c++) buf_q[c][wptr_q] <= datain[c*DW +: DW];
    if (vld_q && last_q) res_q[pch_q] <= sat(sum);
  end
  assign dataout = dout_q;
  assign dataout_valid = oval_q;
  assign busy = state_q != IDLE;
  assign overrun = ovr_q;
  assign coefaddress = state_q == RUN ? tap_q : '0;
endmodule
